// File: rtl/fp_rf_wb_arbiter.sv
// FP register file write-back arbiter: two requesters (FPU result, FP load) each
// queue {addr, data} in a small FIFO; a round-robin pick drives one registered write per cycle.
module fp_rf_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [4:0]  r0_addr,
    input  logic [63:0] r0_data,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [4:0]  r1_addr,
    input  logic [63:0] r1_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic [31:0] busy,
    output logic        idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(2 * DEPTH + 1);

    logic [1:0]    in_valid;
    logic [4:0]    in_addr [2];
    logic [63:0]   in_data [2];

    logic [4:0]    q_addr [2][DEPTH];
    logic [63:0]   q_data [2][DEPTH];
    logic [PW-1:0] wr_ptr [2];
    logic [PW-1:0] rd_ptr [2];
    logic [OW-1:0] occ [2];

    logic [1:0]    ready;
    logic [1:0]    nonempty;
    logic [1:0]    accept;
    logic [1:0]    pop;
    logic          grant;
    logic          last_grant;
    logic [4:0]    head_addr;
    logic [63:0]   head_data;

    logic [CW-1:0] pend [1:31];

    assign in_valid   = {r1_valid, r0_valid};
    assign in_addr[0] = r0_addr;
    assign in_addr[1] = r1_addr;
    assign in_data[0] = r0_data;
    assign in_data[1] = r1_data;

    // Ready looks only at registered occupancy, so a full FIFO never accepts
    // in the same cycle it pops.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready[i]    = (occ[i] < OW'(DEPTH));
            nonempty[i] = (occ[i] != '0);
        end
    end

    assign accept   = in_valid & ready;
    assign r0_ready = ready[0];
    assign r1_ready = ready[1];

    // last_grant = 1 means requester 1 was served last, so requester 0 wins a tie.
    assign pop[0] = nonempty[0] && !(nonempty[1] && !last_grant);
    assign pop[1] = nonempty[1] && !(nonempty[0] && last_grant);
    assign grant  = pop[1];

    assign head_addr = q_addr[grant][rd_ptr[grant]];
    assign head_data = q_data[grant][rd_ptr[grant]];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (accept[i]) begin
                q_addr[i][wr_ptr[i]] <= in_addr[i];
                q_data[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                occ[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                occ[i] <= occ[i] + OW'(accept[i]) - OW'(pop[i]);
            end
        end
    end

    // Address-0 entries still consume an arbitration slot but never write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            last_grant <= 1'b1;
        end else begin
            rf_we <= 1'b0;
            if (|pop) begin
                last_grant <= grant;
                if (head_addr != '0) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= head_addr;
                    rf_wdata <= head_data;
                end
            end
        end
    end

    // Pending writes per register: counts queued entries plus the output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k < 32; k++) begin
                pend[k] <= '0;
            end
        end else begin
            for (int k = 1; k < 32; k++) begin
                pend[k] <= pend[k]
                         + CW'(accept[0] && (in_addr[0] == 5'(k)))
                         + CW'(accept[1] && (in_addr[1] == 5'(k)))
                         - CW'(rf_we && (rf_waddr == 5'(k)));
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int k = 1; k < 32; k++) begin
            busy[k] = (pend[k] != '0);
        end
    end

    assign idle = !nonempty[0] && !nonempty[1] && !rf_we;

endmodule

// File: tb/tb_fp_rf_wb_arbiter.sv
// Bench for fp_rf_wb_arbiter: directed scenarios then random traffic, all checked
// against a queue-based model of the two requesters and the round-robin write port.
module tb_fp_rf_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [4:0]  r0_addr, r1_addr;
    logic [63:0] r0_data, r1_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] busy;
    logic        idle;

    int compared = 0;
    int mismatched = 0;

    typedef logic [68:0] ent_t;
    ent_t        q0[$];
    ent_t        q1[$];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;
    logic        m_last;
    logic        acc0, acc1;

    fp_rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_data(r0_data),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_data(r1_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_we = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_last = 1'b1;
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    // One clock edge of the reference: serve one head (alternate on contention), then enqueue.
    task automatic model_edge();
        bit   g;
        ent_t e;
        acc0 = r0_valid && (q0.size() < DEPTH);
        acc1 = r1_valid && (q1.size() < DEPTH);
        m_we = 1'b0;
        if (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) g = !m_last;
            else g = (q1.size() > 0);
            if (g) e = q1.pop_front();
            else e = q0.pop_front();
            m_last = g;
            if (e[68:64] != 5'd0) begin
                m_we = 1'b1;
                m_waddr = e[68:64];
                m_wdata = e[63:0];
            end
        end
        if (acc0) q0.push_back({r0_addr, r0_data});
        if (acc1) q1.push_back({r1_addr, r1_data});
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        ent_t e;
        b = '0;
        foreach (q0[i]) begin e = q0[i]; b[e[68:64]] = 1'b1; end
        foreach (q1[i]) begin e = q1[i]; b[e[68:64]] = 1'b1; end
        if (m_we) b[m_waddr] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic check_all();
        chk("r0_ready", 64'(r0_ready), 64'(q0.size() < DEPTH));
        chk("r1_ready", 64'(r1_ready), 64'(q1.size() < DEPTH));
        chk("rf_we", 64'(rf_we), 64'(m_we));
        if (m_we) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
            chk("rf_wdata", rf_wdata, m_wdata);
        end
        chk("busy", 64'(busy), 64'(model_busy()));
        chk("idle", 64'(idle), 64'(q0.size() == 0 && q1.size() == 0 && !m_we));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst = 1'b0;
        #1;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [4:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return 5'd0;
        else if (r < 6) return 5'($urandom_range(1, 3));
        else return 5'($urandom_range(1, 31));
    endfunction

    initial begin
        int s0, s1;
        bit hold0, hold1;

        rst = 1'b0;
        r0_valid = 1'b0; r0_addr = '0; r0_data = '0;
        r1_valid = 1'b0; r1_addr = '0; r1_data = '0;
        model_clear();

        @(negedge clk);
        chk("rst_r0_ready", 64'(r0_ready), 64'd1);
        chk("rst_r1_ready", 64'(r1_ready), 64'd1);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        rst = 1'b1;

        // Single write to f5: latency and busy window.
        r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 64'h3FF0_0000_0000_0000;
        step();
        chk("f5_n_we", 64'(rf_we), 64'd0);
        chk("f5_n_busy", 64'(busy[5]), 64'd1);
        r0_valid = 1'b0;
        step();
        chk("f5_n1_we", 64'(rf_we), 64'd1);
        chk("f5_n1_waddr", 64'(rf_waddr), 64'd5);
        chk("f5_n1_wdata", rf_wdata, 64'h3FF0_0000_0000_0000);
        chk("f5_n1_busy", 64'(busy[5]), 64'd1);
        step();
        chk("f5_n2_we", 64'(rf_we), 64'd0);
        chk("f5_n2_busy", 64'(busy[5]), 64'd0);
        chk("f5_n2_idle", 64'(idle), 64'd1);

        // Both requesters streaming from reset: strict alternation starting with r0.
        apply_reset();
        s0 = 0; s1 = 0;
        for (int k = 1; k <= 16; k++) begin
            r0_valid = 1'b1; r0_addr = 5'(1 + s0 % 8);       r0_data = {1'b0, 31'd0, 32'(s0)};
            r1_valid = 1'b1; r1_addr = 5'(1 + (s1 + 4) % 8); r1_data = {1'b1, 31'd0, 32'(s1)};
            step();
            if (acc0) s0++;
            if (acc1) s1++;
            if (k == 2) chk("r1_stall_ready", 64'(r1_ready), 64'd0);
            if (k >= 2) begin
                chk("alt_we", 64'(rf_we), 64'd1);
                chk("alt_src", 64'(rf_wdata[63]), 64'((k - 2) % 2));
            end
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (6) step();

        // Same register from both requesters in one cycle.
        r0_valid = 1'b1; r0_addr = 5'd7; r0_data = 64'hAAAA_0000_0000_0007;
        r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 64'hBBBB_0000_0000_0007;
        step();
        chk("f7_n_busy", 64'(busy[7]), 64'd1);
        r0_valid = 1'b0; r1_valid = 1'b0;
        step();
        chk("f7_w1_we", 64'(rf_we), 64'd1);
        chk("f7_w1_waddr", 64'(rf_waddr), 64'd7);
        chk("f7_w1_busy", 64'(busy[7]), 64'd1);
        step();
        chk("f7_w2_we", 64'(rf_we), 64'd1);
        chk("f7_w2_waddr", 64'(rf_waddr), 64'd7);
        chk("f7_w2_busy", 64'(busy[7]), 64'd1);
        step();
        chk("f7_done_we", 64'(rf_we), 64'd0);
        chk("f7_done_busy", 64'(busy[7]), 64'd0);

        // Write to f0 is swallowed.
        r0_valid = 1'b1; r0_addr = 5'd0; r0_data = 64'h1234;
        step();
        chk("f0_n_idle", 64'(idle), 64'd0);
        chk("f0_n_busy", 64'(busy), 64'd0);
        r0_valid = 1'b0;
        step();
        chk("f0_n1_we", 64'(rf_we), 64'd0);
        chk("f0_n1_busy", 64'(busy), 64'd0);
        chk("f0_n1_idle", 64'(idle), 64'd1);
        step();
        chk("f0_n2_we", 64'(rf_we), 64'd0);

        // Random traffic; a requester holds its request until accepted.
        hold0 = 1'b0; hold1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!hold0) begin
                r0_valid = ($urandom_range(0, 99) < 65);
                r0_addr = rand_addr();
                r0_data = {$urandom(), $urandom()};
            end
            if (!hold1) begin
                r1_valid = ($urandom_range(0, 99) < 65);
                r1_addr = rand_addr();
                r1_data = {$urandom(), $urandom()};
            end
            step();
            hold0 = r0_valid && !acc0;
            hold1 = r1_valid && !acc1;
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (6) step();

        // Reset with both queues loaded: everything in flight is dropped.
        s0 = 0; s1 = 0;
        for (int k = 0; k < 5; k++) begin
            r0_valid = 1'b1; r0_addr = 5'd9;  r0_data = 64'(s0 + 100);
            r1_valid = 1'b1; r1_addr = 5'd10; r1_data = 64'(s1 + 200);
            step();
            if (acc0) s0++;
            if (acc1) s1++;
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_r0_ready", 64'(r0_ready), 64'd1);
        chk("mid_rst_r1_ready", 64'(r1_ready), 64'd1);
        chk("mid_rst_idle", 64'(idle), 64'd1);
        model_clear();
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fp_rf_wb_arbiter.md
FP_RF_WB_ARBITER -- requirements
Module: fp_rf_wb_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 2, per-requester FIFO entries (power of 2, >=2).
REQ-002 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: r0_valid input 1, r0_ready output 1, r0_addr input 5, r0_data input 64; requester 0 (FPU result) write request.
REQ-005 SHALL have ports: r1_valid input 1, r1_ready output 1, r1_addr input 5, r1_data input 64; requester 1 (FP load) write request.
REQ-006 SHALL have ports: rf_we output 1, rf_waddr output 5, rf_wdata output 64; drive the FP register file write port (WE3/A3/WD3).
REQ-007 SHALL have port: busy  output  32  bit k = 1 while any write to f[k] is queued or in the output stage.
REQ-008 SHALL have port: idle  output  1  both FIFOs empty and rf_we = 0.

Function
REQ-009 SHALL hold one FIFO of DEPTH entries {addr, data} per requester.
REQ-010 SHALL accept a request when rN_valid && rN_ready at a rising edge.
REQ-011 SHALL drive rN_ready = (FIFO N occupancy < DEPTH), from registered occupancy only; no same-cycle pop-through.
REQ-012 SHALL select at most one FIFO head per cycle; the popped head loads the registered output stage at the same edge.
REQ-013 SHALL arbitrate round-robin: with both heads valid, grant the requester not granted last; with one valid, grant it without changing fairness beyond recording it as last grant.
REQ-014 SHALL register rf_we/rf_waddr/rf_wdata; rf_we = 1 for exactly one cycle per popped non-zero-address entry, else 0.
REQ-015 SHALL pop entries with addr = 0 in a normal arbitration slot, discard them, keep rf_we = 0, and never count them in busy.
REQ-016 SHALL preserve per-requester order; no ordering is guaranteed between requesters.
REQ-017 SHALL latency: accept at edge N, earliest rf_we = 1 in cycle after edge N+1, register file commits at edge N+2.
REQ-018 SHALL sustain one write per cycle when either FIFO is non-empty.
REQ-019 SHALL keep a pending counter per register, width clog2(2*DEPTH+1); increment on accept of non-zero addr, decrement at the edge where rf_we = 1 for that addr.
REQ-020 SHALL leave a counter unchanged when increment and decrement coincide; both requesters accepting the same addr in one cycle increments by 2.
REQ-021 SHALL drive busy[k] = (counter k != 0); busy[0] = 0 always.
REQ-022 SHALL not change FIFO state when rN_valid is asserted while rN_ready = 0; requester must hold data.

Reset
REQ-023 SHALL on rst = 0, asynchronously clear FIFOs, counters, and output stage: rN_ready = 1, rf_we = 0, rf_waddr = 0, rf_wdata = 0, busy = 0, idle = 1.
REQ-024 SHALL set last-grant to requester 1 on reset so requester 0 wins the first contention.
REQ-025 SHALL discard all queued and in-flight writes on reset mid-operation; no rf_we pulse after rst deasserts until a new accept.

Verification
REQ-026 SHALL cover: r0 writes f5 = 64'h3FF0_0000_0000_0000 alone -> rf_we = 1, rf_waddr = 5 in cycle after edge N+1; busy[5] 1 from after N to commit edge.
REQ-027 SHALL cover: r0 and r1 valid every cycle from reset, addrs 1..8 -> grants alternate r0,r1,r0,...; rf_we = 1 every cycle; per-requester order kept.
REQ-028 SHALL cover: r1_valid held with no grant opportunity (r0 contending, DEPTH = 2) -> r1_ready = 0 after 2 accepts, no entry lost or duplicated.
REQ-029 SHALL cover: r0 and r1 both write f7 same cycle -> counter 7 = 2, two rf_we pulses, busy[7] clears after second commit only.
REQ-030 SHALL cover: write to f0 -> accepted, rf_we stays 0, busy unchanged, idle returns to 1.
REQ-031 SHALL cover: rst asserted with both FIFOs full -> immediately rf_we = 0, busy = 0, r0_ready = r1_ready = 1, no stale write after release.
